// File: rtl/lat_unit_ctrl.sv
// ============================================================================
// Module  : lat_unit_ctrl
// Brief   : Sequencer for the iterative divider and multi-cycle FPU: captures
//           one op, launches one unit, holds its result until writeback acks.
//           Optional watchdog enabled by defining macro LU_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lat_unit_ctrl #(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_issue_vld,
  input  logic [1:0]      i_issue_unit,
  input  logic [4:0]      i_issue_func,
  input  logic [2:0]      i_issue_rm,
  input  logic [XLEN-1:0] i_issue_opa,
  input  logic [XLEN-1:0] i_issue_opb,
  output logic            o_issue_rdy,
  input  logic            i_flush,
  output logic            o_div_start,
  output logic            o_fpu_start,
  output logic [XLEN-1:0] o_unit_opa,
  output logic [XLEN-1:0] o_unit_opb,
  output logic [4:0]      o_unit_func,
  output logic [2:0]      o_unit_rm,
  input  logic            i_div_done,
  input  logic [XLEN-1:0] i_div_res,
  input  logic            i_fpu_done,
  input  logic [XLEN-1:0] i_fpu_res,
  output logic            o_res_vld,
  output logic [XLEN-1:0] o_res_data,
  input  logic            i_res_ack,
  output logic            o_stall,
  output logic            o_err_timeout
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_LAUNCH = 3'd1;
  localparam logic [2:0] c_WAIT   = 3'd2;
  localparam logic [2:0] c_HOLD   = 3'd3;
  localparam logic [2:0] c_DRAIN  = 3'd4;

  localparam logic [XLEN-1:0] c_TMO_RES = XLEN'(32'hbaadbeef);

  logic [2:0]      r_state;
  logic [2:0]      w_next;
  logic            r_sel_fpu;
  logic [XLEN-1:0] r_opa;
  logic [XLEN-1:0] r_opb;
  logic [4:0]      r_func;
  logic [2:0]      r_rm;
  logic [XLEN-1:0] r_res;
  logic            w_unit_ok;
  logic            w_accept;
  logic            w_done;
  logic            w_tmo;

  assign w_unit_ok = (i_issue_unit == 2'b01) || (i_issue_unit == 2'b10);
  assign w_accept  = (r_state == c_IDLE) && i_issue_vld && w_unit_ok && !i_flush;
  // Only the launched unit's done pulse is meaningful.
  assign w_done    = r_sel_fpu ? i_fpu_done : i_div_done;

`ifdef LU_TIMEOUT_EN
  localparam int c_CW = $clog2(TIMEOUT_CYC + 1);

  logic [c_CW-1:0] r_wdog;
  logic            r_err;
  logic            w_busy;

  assign w_busy = (r_state == c_WAIT) || (r_state == c_DRAIN);
  assign w_tmo  = w_busy && (r_wdog >= c_CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == c_LAUNCH) begin
        r_wdog <= '0;
      end else if (w_busy && !w_tmo) begin
        r_wdog <= r_wdog + 1'b1;
      end
      if (w_tmo && !w_done) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_err_timeout = r_err;
`else
  assign w_tmo         = 1'b0;
  assign o_err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:   if (w_accept) w_next = c_LAUNCH;
      c_LAUNCH: w_next = i_flush ? c_DRAIN : c_WAIT;
      c_WAIT: begin
        if (w_done)       w_next = i_flush ? c_IDLE : c_HOLD;
        else if (i_flush) w_next = c_DRAIN;
        else if (w_tmo)   w_next = c_HOLD;
      end
      c_HOLD:   if (i_flush || i_res_ack) w_next = c_IDLE;
      c_DRAIN:  if (w_done || w_tmo) w_next = c_IDLE;
      default:  w_next = c_IDLE;
    endcase
  end

  always_comb begin
    o_issue_rdy = (r_state == c_IDLE);
    o_div_start = (r_state == c_LAUNCH) && !r_sel_fpu;
    o_fpu_start = (r_state == c_LAUNCH) && r_sel_fpu;
    o_res_vld   = (r_state == c_HOLD);
    o_stall     = 1'b0;
    case (r_state)
      c_IDLE:   o_stall = w_accept;
      c_LAUNCH: o_stall = 1'b1;
      c_WAIT:   o_stall = 1'b1;
      c_HOLD:   o_stall = !i_res_ack;
      default:  o_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_fpu <= 1'b0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_func    <= '0;
      r_rm      <= '0;
      r_res     <= '0;
    end else begin
      if (w_accept) begin
        r_sel_fpu <= (i_issue_unit == 2'b10);
        r_opa     <= i_issue_opa;
        r_opb     <= i_issue_opb;
        r_func    <= i_issue_func;
        r_rm      <= i_issue_rm;
      end
      // A WAIT->HOLD move is either a real done or a watchdog expiry.
      if ((r_state == c_WAIT) && (w_next == c_HOLD)) begin
        r_res <= w_done ? (r_sel_fpu ? i_fpu_res : i_div_res) : c_TMO_RES;
      end
    end
  end

  assign o_unit_opa  = r_opa;
  assign o_unit_opb  = r_opb;
  assign o_unit_func = r_func;
  assign o_unit_rm   = r_rm;
  assign o_res_data  = r_res;

endmodule

`default_nettype wire

// File: doc/lat_unit_ctrl.md
Name: lat_unit_ctrl

Overview:
Sequencer for the long-latency execute resources: the iterative divider and the multi-cycle FPU.
- Accepts one multi-cycle op from the EX issue point and captures its operands.
- Launches exactly one unit, waits for its done pulse, then holds the result until writeback acknowledges it.
- Drives the pipeline stall and handles flushes of in-flight ops.

Parameters:
XLEN, 32, operand/result width
TIMEOUT_CYC, 64, watchdog limit in cycles (used only with LU_TIMEOUT_EN)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
issue_vld  in  1  op presented this cycle
issue_unit  in  2  target: 00 none, 01 divider, 10 FPU, 11 reserved
issue_func  in  5  ALU function code, forwarded to the unit
issue_rm  in  3  FP rounding mode
issue_opa  in  XLEN  operand A
issue_opb  in  XLEN  operand B
issue_rdy  out  1  controller can accept an op
flush  in  1  kill the current op
div_start  out  1  one-cycle launch pulse to divider
fpu_start  out  1  one-cycle launch pulse to FPU
unit_opa  out  XLEN  registered operand A
unit_opb  out  XLEN  registered operand B
unit_func  out  5  registered function code
unit_rm  out  3  registered rounding mode
div_done  in  1  divider result valid pulse
div_res  in  XLEN  divider result
fpu_done  in  1  FPU result valid pulse
fpu_res  in  XLEN  FPU result
res_vld  out  1  result held for writeback
res_data  out  XLEN  held result
res_ack  in  1  writeback consumed the result
stall  out  1  hold upstream pipeline
err_timeout  out  1  sticky watchdog flag

Behaviour:
Reset (rst=0, asynchronous):
- state=IDLE.
- All outputs 0 except issue_rdy=1.
- unit_* registers, res_data and the watchdog counter are 0.
- Reset mid-operation abandons the op; a late done pulse arriving in IDLE is ignored.

States: IDLE, LAUNCH, WAIT, HOLD, DRAIN.

IDLE:
- issue_rdy=1.
- Accept when issue_vld=1, issue_unit is 01 or 10, and flush=0.
- On accept: capture opa/opb/func/rm and the unit select, go to LAUNCH.
- issue_unit of 00 or 11 is ignored: no state change, no stall.
- flush together with issue_vld: flush wins, the op is not accepted.

LAUNCH (exactly 1 cycle):
- Exactly one of div_start/fpu_start is 1, per the captured unit select.
- Next state: WAIT, or DRAIN if flush=1.
- Done pulses are ignored in LAUNCH.

WAIT:
- Only the selected unit's done is observed; the other unit's done is ignored.
- On done: capture the matching result into res_data, set res_vld=1 next cycle, go to HOLD.
- flush=1 without done: go to DRAIN.
- flush=1 together with done: result discarded, go to IDLE.

DRAIN:
- The unit cannot be aborted, so the controller waits for the selected done, discards the result, then goes to IDLE.
- Further flushes have no effect.

HOLD:
- res_vld=1 and res_data stable until res_ack=1.
- On res_ack: res_vld falls the next cycle, go to IDLE.
- flush=1 in HOLD: drop the result (res_vld=0 next cycle), go to IDLE. flush has priority over res_ack.

Outputs:
- issue_rdy = (state==IDLE).
- stall, combinational:
  - IDLE: issue_vld && issue_unit∈{01,10} && !flush.
  - LAUNCH, WAIT: 1.
  - DRAIN: 0 (the killed instruction no longer holds the pipe).
  - HOLD: !res_ack.
- Latency, with accept at cycle 0: start pulse at cycle 1. If done is sampled at cycle N (N≥2), res_vld=1 from cycle N+1. Minimum accept-to-res_vld is 3 cycles.
- Back-to-back ops: the next accept is at the earliest in the cycle after res_ack.

Optional Feature:
Macro LU_TIMEOUT_EN.
- Defined:
  - A counter clears on entering LAUNCH and increments each cycle in WAIT or DRAIN.
  - When it reaches TIMEOUT_CYC without done:
    - err_timeout sets; it is sticky until reset.
    - WAIT goes to HOLD with res_data=32'hbaadbeef.
    - DRAIN goes to IDLE.
  - A later stray done is ignored.
- Not defined: no counter is present, err_timeout is tied 0, and WAIT/DRAIN wait indefinitely.

Test Plan:
1. Reset, then issue DIV opa=100 opb=7 (unit 01), divider done at cycle 5 with res 14 → div_start=1 only at cycle 1; stall=1 cycles 0–5; res_vld=1 with res_data=14 from cycle 6; res_ack at cycle 8 → IDLE at 9, issue_rdy=1.
2. FPU op (unit 10) with opa=0x3F800000, opb=0x40000000, fpu_done at cycle 3 with res 0x40400000 → fpu_start only, res_data=0x40400000 at cycle 4; div_done pulse injected at cycle 2 is ignored.
3. flush at cycle 2 of a divide, div_done at cycle 6 → DRAIN; stall=0 from cycle 3; res_vld never asserts; IDLE at cycle 7.
4. issue_vld with flush in the same cycle, and issue_unit=11 → no accept, no start pulse, stall=0.
5. HOLD with flush and res_ack together → res_vld=0 next cycle, state IDLE, no writeback.
6. LU_TIMEOUT_EN defined, TIMEOUT_CYC=8, done never arrives → err_timeout=1 and res_data=0xbaadbeef with res_vld=1 after 8 WAIT cycles; err_timeout stays 1 after res_ack until rst=0.
